// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data stream bundle used on both sides of the skid pipeline stage.
// The master drives valid and data. The slave drives ready.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 256
) ();
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a valid/ready handshake, a two-entry skid buffer,
// flush, forwarding taps and a saturating stall counter.
module pipe_stage_skid #(
   parameter int DATA_W  = 256,
   parameter int RD_LSB  = 0,
   parameter int WEN_BIT = 5,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               rst,
   pipe_stage_skid_if.slave   up,
   pipe_stage_skid_if.master  dn,
   input  logic               flush,
   output logic               fwd0_wen,
   output logic [4:0]         fwd0_rd,
   output logic               fwd1_wen,
   output logic [4:0]         fwd1_rd,
   output logic [1:0]         occupancy,
   output logic [CNT_W-1:0]   stall_cnt,
   input  logic               cnt_clr
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_reg;
   logic [DATA_W-1:0] head_reg;
   logic [DATA_W-1:0] skid_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;

   logic in_ready;
   logic out_valid;
   logic skid_valid;
   logic push;
   logic pop;

   // The ready/valid outputs decode registered state only, so there is no combinational path from dn.ready to up.ready.
   assign in_ready   = (state_reg != FULL);
   assign out_valid  = (state_reg != EMPTY);
   assign skid_valid = (state_reg == FULL);
   assign push       = up.valid && in_ready;
   assign pop        = out_valid && dn.ready;

   assign up.ready  = in_ready;
   assign dn.valid  = out_valid;
   assign dn.data   = head_reg;

   assign fwd0_wen  = out_valid && head_reg[WEN_BIT];
   assign fwd0_rd   = head_reg[RD_LSB +: 5];
   assign fwd1_wen  = skid_valid && skid_reg[WEN_BIT];
   assign fwd1_rd   = skid_reg[RD_LSB +: 5];
   assign occupancy = state_reg;
   assign stall_cnt = stall_cnt_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= EMPTY;
         head_reg      <= '0;
         skid_reg      <= '0;
         stall_cnt_reg <= '0;
      end else begin
         if (cnt_clr) begin
            stall_cnt_reg <= '0;
         end else if (out_valid && !dn.ready && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
         end

         // A pop during a flush still completes because the downstream stage has already taken head_reg.
         if (flush) begin
            state_reg <= EMPTY;
         end else begin
            case (state_reg)
               EMPTY: begin
                  if (push) begin
                     head_reg  <= up.data;
                     state_reg <= ONE;
                  end
               end
               ONE: begin
                  if (push && pop) begin
                     head_reg <= up.data;
                  end else if (push) begin
                     skid_reg  <= up.data;
                     state_reg <= FULL;
                  end else if (pop) begin
                     state_reg <= EMPTY;
                  end
               end
               FULL: begin
                  if (pop) begin
                     head_reg  <= skid_reg;
                     state_reg <= ONE;
                  end
               end
               default: state_reg <= EMPTY;
            endcase
         end
      end
   end

endmodule
